br_result_queue: RTL and testbench
==================================

# br_result_queue

Buffers resolved branch outcomes from the integer execution lanes and delivers them in order to the branch predictor's result port (`brResult`), which drives PHT counter training and speculative-history recovery. The block computes the misprediction flag, absorbs bursts while the predictor is busy or in its reset sequence, and never issues two updates to the same PHT bank in one cycle.

## Interface
- `LANES`, 2: execution lanes in and predictor result ports out (matches INT_ISSUE_WIDTH).
- `DEPTH`, 8: FIFO entries; power of two, at least 2*LANES.
- `ADDR_W`, 32: branch address width.
- `HIST_W`, 4: per-address history width (PHT_PAP_BITS).
- `CNT_W`, 2: saturating counter width; prev-entry width is CNT_W<<HIST_W.
- `BANK_LSB`, 2: LSB of the PHT bank-select field in the address (INSN_ADDR_BIT_WIDTH).
- `BANK_BITS`, 1: bank-select width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `exValid[LANES]`  in  1  lane carries a resolved branch.
- `exAddr[LANES]`  in  ADDR_W  branch PC.
- `exTaken[LANES]`, `exPredTaken[LANES]`, `exIsCondBr[LANES]`  in  1 each  actual direction, predicted direction, conditional flag.
- `exPrevEntry[LANES]`  in  CNT_W<<HIST_W  counter snapshot taken at fetch.
- `exPrevHist[LANES]`  in  HIST_W  history snapshot taken at fetch.
- `exReady`  out  1  block accepts LANES results this cycle.
- `predHold`  in  1  predictor busy or resetting; no dequeue.
- `brValid[LANES]`, `brAddr[LANES]`, `brTaken[LANES]`, `brIsCondBr[LANES]`, `brMispred[LANES]`, `brPrevEntry[LANES]`, `brPrevHist[LANES]`  out  as above  registered result to predictor.
- `occupancy`  out  clog2(DEPTH)+1  entries stored.
- `overflow`  out  1  sticky: a valid lane was presented while exReady was low.

## Operation
- Mispred = exIsCondBr && (exTaken != exPredTaken). It is computed at enqueue and stored. Unconditional branches always carry mispred 0.
- Enqueue: valid lanes are written in lane order (lane 0 first) into consecutive slots. Invalid lanes leave no gaps.
- exReady = (DEPTH - occupancy) >= LANES, computed from the registered occupancy only. Same-cycle dequeues do not raise it.
- A valid lane presented while exReady is low is dropped and sets `overflow`. Only reset clears `overflow`.
- Dequeue happens only when predHold = 0. Output port 0 takes the head entry if one exists.
- Output port k>0 takes head+k only if all of the following hold:
  - port k-1 was filled this cycle;
  - the entry exists;
  - its bank field addr[BANK_LSB +: BANK_BITS] differs from the bank fields of every entry already selected this cycle.
- The first entry that fails this test ends selection for the cycle. Order is strictly preserved and entries are never reordered.
- Selected entries load into the output register and leave the FIFO. Unselected output ports load brValid = 0. Their data fields hold their previous values.
- Pointers wrap modulo DEPTH. occupancy_next = occupancy + enq_count - deq_count; enqueue and dequeue in the same cycle are both counted.

## Timing
- Reset (rst low, asynchronous) forces:
  - brValid all 0 and all br* data fields 0;
  - occupancy 0, overflow 0, pointers 0;
  - exReady = 1 immediately.
- Reset may assert mid-drain. Buffered entries are discarded.
- Latency: a lane sampled at edge E is eligible for selection in the cycle after E. It appears on brValid after edge E+1 at the earliest, so it is visible one cycle after it is written.
- brValid is high for exactly one cycle per entry. The predictor has no backpressure beyond predHold.
- If predHold rises, brValid is 0 from the next edge onward. Entries already presented are not re-sent.
- Full: with occupancy > DEPTH-LANES, exReady = 0. Empty: brValid = 0.

## Test plan
- Lane 0 valid, addr 0x100, taken=1, pred=0, cond=1; FIFO empty; predHold=0 -> one cycle after sampling: brValid[0]=1, brAddr=0x100, brMispred=1, brValid[1]=0; occupancy returns to 0.
- Both lanes valid, addrs 0x100 and 0x108 (same bank, bit2=0) -> cycle k: port 0 carries 0x100, brValid[1]=0. Cycle k+1: port 0 carries 0x108.
- Both lanes valid, addrs 0x100 and 0x104 (different banks) -> same cycle: port 0 = 0x100, port 1 = 0x104.
- predHold=1, four cycles of two valid lanes -> occupancy 8, exReady=0 from occupancy 8. A fifth push sets overflow=1 and occupancy stays 8. Release predHold with distinct-bank pairs -> FIFO drains in 4 cycles in order.
- Unconditional branch, taken=1, pred=0 -> brMispred=0, brIsCondBr=0.
- Async reset asserted mid-drain with occupancy 5 -> brValid, occupancy and overflow all 0 immediately, without waiting for a clock edge; after reset release the first new push emerges normally.

Source files
------------

// File: rtl/br_result_queue.sv
// In-order queue of resolved branch outcomes feeding the predictor's result port.
// Computes mispredict at enqueue; dequeue never sends two entries to the same PHT bank per cycle.
module br_result_queue #(
  parameter int LANES     = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 32,
  parameter int HIST_W    = 4,
  parameter int CNT_W     = 2,
  parameter int BANK_LSB  = 2,
  parameter int BANK_BITS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0]              exValid,
  input  logic [ADDR_W-1:0]             exAddr      [LANES],
  input  logic [LANES-1:0]              exTaken,
  input  logic [LANES-1:0]              exPredTaken,
  input  logic [LANES-1:0]              exIsCondBr,
  input  logic [(CNT_W<<HIST_W)-1:0]    exPrevEntry [LANES],
  input  logic [HIST_W-1:0]             exPrevHist  [LANES],
  output logic                          exReady,
  input  logic                          predHold,
  output logic [LANES-1:0]              brValid,
  output logic [ADDR_W-1:0]             brAddr      [LANES],
  output logic [LANES-1:0]              brTaken,
  output logic [LANES-1:0]              brIsCondBr,
  output logic [LANES-1:0]              brMispred,
  output logic [(CNT_W<<HIST_W)-1:0]    brPrevEntry [LANES],
  output logic [HIST_W-1:0]             brPrevHist  [LANES],
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          overflow
);

  localparam int PE_W  = CNT_W << HIST_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
    logic              cond;
    logic              mispred;
    logic [PE_W-1:0]   prev_entry;
    logic [HIST_W-1:0] prev_hist;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             out_q [LANES];
  entry_t             out_d [LANES];
  logic [LANES-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               overflow_q, overflow_d;
  logic [OCC_W-1:0]   enq_cnt, deq_cnt;
  logic [PTR_W-1:0]   wr_idx, rd_idx;
  logic               go, clash;

  // Readiness looks only at registered occupancy so a same-cycle dequeue never widens the window.
  assign exReady = ((DEPTH - int'(occ_q)) >= LANES);

  always_comb begin
    mem_d   = mem_q;
    enq_cnt = '0;
    wr_idx  = wr_ptr_q;
    for (int l = 0; l < LANES; l++) begin
      if (exValid[l] && exReady) begin
        mem_d[wr_idx] = '{addr:       exAddr[l],
                          taken:      exTaken[l],
                          cond:       exIsCondBr[l],
                          mispred:    exIsCondBr[l] & (exTaken[l] ^ exPredTaken[l]),
                          prev_entry: exPrevEntry[l],
                          prev_hist:  exPrevHist[l]};
        wr_idx  = wr_idx + PTR_W'(1);
        enq_cnt = enq_cnt + OCC_W'(1);
      end
    end
    wr_ptr_d   = wr_idx;
    overflow_d = overflow_q | ((|exValid) & ~exReady);
  end

  // Selection stops at the first entry that is missing or collides with a bank already chosen.
  always_comb begin
    out_d   = out_q;
    valid_d = '0;
    deq_cnt = '0;
    rd_idx  = rd_ptr_q;
    go      = ~predHold;
    clash   = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      clash = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (mem_q[rd_ptr_q + PTR_W'(j)].addr[BANK_LSB +: BANK_BITS] ==
            mem_q[rd_idx].addr[BANK_LSB +: BANK_BITS])
          clash = 1'b1;
      end
      if (go && (OCC_W'(k) < occ_q) && !clash) begin
        valid_d[k] = 1'b1;
        out_d[k]   = mem_q[rd_idx];
        rd_idx     = rd_idx + PTR_W'(1);
        deq_cnt    = deq_cnt + OCC_W'(1);
      end else begin
        go = 1'b0;
      end
    end
    rd_ptr_d = rd_idx;
    occ_d    = occ_q + enq_cnt - deq_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q      <= '{default: '0};
      out_q      <= '{default: '0};
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      brAddr[k]      = out_q[k].addr;
      brTaken[k]     = out_q[k].taken;
      brIsCondBr[k]  = out_q[k].cond;
      brMispred[k]   = out_q[k].mispred;
      brPrevEntry[k] = out_q[k].prev_entry;
      brPrevHist[k]  = out_q[k].prev_hist;
    end
  end

  assign brValid   = valid_q;
  assign occupancy = occ_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_br_result_queue.sv
// Directed bench for br_result_queue: scoreboard of expected results, checked as the DUT emits them.
module tb_br_result_queue;

  logic        clk;
  logic        rst;
  logic [1:0]  exValid, exTaken, exPredTaken, exIsCondBr;
  logic [31:0] exAddr      [2];
  logic [31:0] exPrevEntry [2];
  logic [3:0]  exPrevHist  [2];
  logic        exReady;
  logic        predHold;
  logic [1:0]  brValid, brTaken, brIsCondBr, brMispred;
  logic [31:0] brAddr      [2];
  logic [31:0] brPrevEntry [2];
  logic [3:0]  brPrevHist  [2];
  logic [3:0]  occupancy;
  logic        overflow;

  br_result_queue dut (
    .clk(clk), .rst(rst),
    .exValid(exValid), .exAddr(exAddr), .exTaken(exTaken), .exPredTaken(exPredTaken),
    .exIsCondBr(exIsCondBr), .exPrevEntry(exPrevEntry), .exPrevHist(exPrevHist),
    .exReady(exReady), .predHold(predHold),
    .brValid(brValid), .brAddr(brAddr), .brTaken(brTaken), .brIsCondBr(brIsCondBr),
    .brMispred(brMispred), .brPrevEntry(brPrevEntry), .brPrevHist(brPrevHist),
    .occupancy(occupancy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        taken;
    logic        cond;
    logic        mispred;
    logic [31:0] pe;
    logic [3:0]  hist;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input logic [31:0] addr, input logic taken,
                      input logic pred, input logic cond, input bit track);
    exp_t e;
    exValid[lane]     = 1'b1;
    exAddr[lane]      = addr;
    exTaken[lane]     = taken;
    exPredTaken[lane] = pred;
    exIsCondBr[lane]  = cond;
    exPrevEntry[lane] = addr ^ 32'hA5A5_0000;
    exPrevHist[lane]  = addr[7:4];
    if (track) begin
      e.addr = addr; e.taken = taken; e.cond = cond;
      e.mispred = cond && (taken != pred);
      e.pe = addr ^ 32'hA5A5_0000; e.hist = addr[7:4];
      sb.push_back(e);
    end
  endtask

  // Advance one edge, sample 1ns later, and retire any emitted results against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (brValid[p] === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed port %0d addr %0h expected no output", p, brAddr[p]);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_addr",   64'(brAddr[p]),      64'(e.addr));
          chk("sb_taken",  64'(brTaken[p]),     64'(e.taken));
          chk("sb_cond",   64'(brIsCondBr[p]),  64'(e.cond));
          chk("sb_mispr",  64'(brMispred[p]),   64'(e.mispred));
          chk("sb_pentry", 64'(brPrevEntry[p]), 64'(e.pe));
          chk("sb_phist",  64'(brPrevHist[p]),  64'(e.hist));
        end
      end
    end
    exValid = '0;
  endtask

  initial begin
    rst = 1'b0; predHold = 1'b0;
    exValid = '0; exTaken = '0; exPredTaken = '0; exIsCondBr = '0;
    for (int l = 0; l < 2; l++) begin
      exAddr[l] = '0; exPrevEntry[l] = '0; exPrevHist[l] = '0;
    end
    #3;
    chk("rst_valid", 64'(brValid), 64'd0);
    chk("rst_addr0", 64'(brAddr[0]), 64'd0);
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_ready", 64'(exReady), 64'd1);
    #4 rst = 1'b1;

    // single conditional mispredict
    push(0, 32'h100, 1, 0, 1, 1);
    tick();
    chk("t1_occ_in",   64'(occupancy), 64'd1);
    chk("t1_val_lat",  64'(brValid), 64'd0);
    tick();
    chk("t1_valid",    64'(brValid), 64'b01);
    chk("t1_mispred",  64'(brMispred[0]), 64'd1);
    chk("t1_occ_out",  64'(occupancy), 64'd0);

    // same bank: serialised over two cycles
    push(0, 32'h100, 0, 0, 1, 1);
    push(1, 32'h108, 1, 1, 1, 1);
    tick();
    tick();
    chk("t2_k_valid",  64'(brValid), 64'b01);
    chk("t2_k_addr",   64'(brAddr[0]), 64'h100);
    tick();
    chk("t2_k1_valid", 64'(brValid), 64'b01);
    chk("t2_k1_addr",  64'(brAddr[0]), 64'h108);
    tick();
    chk("t2_idle",     64'(brValid), 64'd0);

    // different banks: both in one cycle
    push(0, 32'h100, 1, 1, 1, 1);
    push(1, 32'h104, 0, 1, 1, 1);
    tick();
    tick();
    chk("t3_valid",    64'(brValid), 64'b11);
    chk("t3_addr1",    64'(brAddr[1]), 64'h104);
    tick();

    // fill under hold, overflow, then drain
    predHold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h200 + 32'(i*8), i[0], 1'b0, 1'b1, 1);
      push(1, 32'h204 + 32'(i*8), 1'b1, i[1], 1'b1, 1);
      tick();
      chk("hold_occ",   64'(occupancy), 64'(2*(i+1)));
      chk("hold_valid", 64'(brValid), 64'd0);
    end
    chk("full_ready", 64'(exReady), 64'd0);
    push(0, 32'h300, 1, 0, 1, 0);
    push(1, 32'h304, 1, 0, 1, 0);
    tick();
    chk("ovf_set",  64'(overflow), 64'd1);
    chk("ovf_occ",  64'(occupancy), 64'd8);
    predHold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_valid", 64'(brValid), 64'b11);
      chk("drain_occ",   64'(occupancy), 64'(6 - 2*i));
    end
    tick();
    chk("drain_idle", 64'(brValid), 64'd0);

    // unconditional branch never mispredicts
    push(0, 32'h400, 1, 0, 0, 1);
    tick();
    tick();
    chk("unc_valid", 64'(brValid), 64'b01);
    chk("unc_mispr", 64'(brMispred[0]), 64'd0);
    chk("unc_cond",  64'(brIsCondBr[0]), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // async reset mid-drain
    predHold = 1'b1;
    push(0, 32'h500, 1, 0, 1, 1);
    push(1, 32'h504, 0, 0, 1, 1);
    tick();
    push(0, 32'h508, 1, 1, 1, 1);
    push(1, 32'h50C, 0, 1, 1, 1);
    tick();
    push(0, 32'h510, 1, 0, 0, 1);
    tick();
    chk("mid_occ5", 64'(occupancy), 64'd5);
    predHold = 1'b0;
    tick();
    chk("mid_valid", 64'(brValid), 64'b11);
    chk("mid_occ3",  64'(occupancy), 64'd3);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(brValid), 64'd0);
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_ovf",   64'(overflow), 64'd0);
    chk("arst_ready", 64'(exReady), 64'd1);
    sb.delete();
    #2 rst = 1'b1;
    push(0, 32'h600, 0, 1, 1, 1);
    tick();
    chk("post_occ", 64'(occupancy), 64'd1);
    tick();
    chk("post_valid", 64'(brValid), 64'b01);
    chk("post_addr",  64'(brAddr[0]), 64'h600);
    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
